// File: rtl/rc4_decrypt_core.sv
// rc4_decrypt_core: self-contained RC4 engine (S-box init, key schedule, PRGA
// decrypt) driving external single-port S RAM, encrypted ROM and decrypted RAM.
// Memory reads: address in cycle n, data sampled at the end of cycle n+1.
// Timing: INIT 256 cycles, T_ksa = 6 cycles per KSA iteration,
// T_prga = 8 cycles per PRGA byte; total busy = 256 + 256*6 + n*8.
module rc4_decrypt_core #(
  parameter int KEY_LENGTH  = 3,
  parameter int MSG_LENGTH  = 32,
  parameter bit CHECK_ASCII = 1'b1,
  parameter int AW          = $clog2(MSG_LENGTH)
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    start,
  input  logic [8*KEY_LENGTH-1:0] secret_key,
  output logic [7:0]              s_address,
  output logic [7:0]              s_data,
  output logic                    s_wren,
  input  logic [7:0]              s_q,
  output logic [AW-1:0]           enc_address,
  input  logic [7:0]              enc_q,
  output logic [AW-1:0]           dec_address,
  output logic [7:0]              dec_data,
  output logic                    dec_wren,
  output logic                    busy,
  output logic                    done,
  output logic                    key_valid
);

  typedef enum logic [4:0] {
    ST_IDLE, ST_INIT,
    K_RDI, K_WI, K_RDJ, K_WJ, K_WRI, K_WRJ,
    P_RDI, P_WI, P_RDJ, P_WJ, P_WRI, P_WRJ, P_RDF, P_WF,
    ST_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [5:0]              kidx_q, kidx_d;
  logic [AW-1:0]           k_q, k_d;
  logic [8*KEY_LENGTH-1:0] key_q, key_d;
  logic                    valid_q, valid_d;
  logic [7:0]              keyByte;
  logic [7:0]              plainByte;
  logic                    plainOk;

  // Select key byte (i mod KEY_LENGTH) from the latched key, MSB byte first
  always_comb begin
    keyByte = 8'h00;
    for (int b = 0; b < KEY_LENGTH; b++) begin
      if (kidx_q == 6'(b)) keyByte = key_q[8*(KEY_LENGTH-1-b) +: 8];
    end
  end

  assign plainByte = s_q ^ enc_q;
  assign plainOk   = !CHECK_ASCII ||
                     ((plainByte >= 8'h61) && (plainByte <= 8'h7A)) ||
                     (plainByte == 8'h20);

  // State register with synchronous reset
  always_ff @(posedge CLOCK_50) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers: indices, swap operands, latched key and verdict
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      i_q <= '0; j_q <= '0; si_q <= '0; sj_q <= '0;
      kidx_q <= '0; k_q <= '0; key_q <= '0; valid_q <= 1'b0;
    end else begin
      i_q <= i_d; j_q <= j_d; si_q <= si_d; sj_q <= sj_d;
      kidx_q <= kidx_d; k_q <= k_d; key_q <= key_d; valid_q <= valid_d;
    end
  end

  // Next-state and datapath update logic for the three RC4 phases
  always_comb begin
    state_d = state_q;
    i_d = i_q; j_d = j_q; si_d = si_q; sj_d = sj_q;
    kidx_d = kidx_q; k_d = k_q; key_d = key_q; valid_d = valid_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          key_d = secret_key;
          i_d = '0; j_d = '0; kidx_d = '0; k_d = '0; valid_d = 1'b0;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        i_d = i_q + 8'd1;
        if (i_q == 8'd255) state_d = K_RDI;
      end
      K_RDI: state_d = K_WI;
      K_WI: begin
        si_d = s_q;
        j_d = j_q + s_q + keyByte;
        state_d = K_RDJ;
      end
      K_RDJ: state_d = K_WJ;
      K_WJ: begin
        sj_d = s_q;
        state_d = K_WRI;
      end
      K_WRI: state_d = K_WRJ;
      K_WRJ: begin
        i_d = i_q + 8'd1;
        kidx_d = (kidx_q == 6'(KEY_LENGTH - 1)) ? 6'd0 : kidx_q + 6'd1;
        if (i_q == 8'd255) begin
          j_d = '0;
          k_d = '0;
          state_d = P_RDI;
        end else begin
          state_d = K_RDI;
        end
      end
      P_RDI: begin
        i_d = i_q + 8'd1;
        state_d = P_WI;
      end
      P_WI: begin
        si_d = s_q;
        j_d = j_q + s_q;
        state_d = P_RDJ;
      end
      P_RDJ: state_d = P_WJ;
      P_WJ: begin
        sj_d = s_q;
        state_d = P_WRI;
      end
      P_WRI: state_d = P_WRJ;
      P_WRJ: state_d = P_RDF;
      P_RDF: state_d = P_WF;
      P_WF: begin
        if (!plainOk) begin
          valid_d = 1'b0;
          state_d = ST_DONE;
        end else if (k_q == AW'(MSG_LENGTH - 1)) begin
          valid_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          k_d = k_q + 1'b1;
          state_d = P_RDI;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory strobes and status outputs decoded from the current state
  always_comb begin
    s_address = '0; s_data = '0; s_wren = 1'b0;
    enc_address = '0; dec_address = '0; dec_data = '0; dec_wren = 1'b0;
    busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
    done = (state_q == ST_DONE);
    key_valid = (state_q == ST_DONE) && valid_q;
    case (state_q)
      ST_INIT: begin
        s_address = i_q; s_data = i_q; s_wren = 1'b1;
      end
      K_RDI, K_WI, P_WI:  s_address = i_q;
      P_RDI:              s_address = i_q + 8'd1;
      K_RDJ, K_WJ, P_RDJ, P_WJ: s_address = j_q;
      K_WRI, P_WRI: begin
        s_address = i_q; s_data = sj_q; s_wren = 1'b1;
      end
      K_WRJ, P_WRJ: begin
        s_address = j_q; s_data = si_q; s_wren = 1'b1;
      end
      P_RDF: s_address = si_q + sj_q;
      P_WF: begin
        s_address = si_q + sj_q;
        dec_address = k_q; dec_data = plainByte; dec_wren = 1'b1;
      end
      default: ;
    endcase
    if ((state_q >= P_RDI) && (state_q <= P_WF)) enc_address = k_q;
  end

endmodule

// File: tb/tb_rc4_decrypt_core.sv
// tb_rc4_decrypt_core: two cores (full decrypt / ASCII abort) against a
// software RC4 model, with behavioural single-port memories around each.
module tb_rc4_decrypt_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startA = 1'b0, startB = 1'b0;
  logic [23:0] keyA = '0, keyB = '0;

  logic [7:0] sAddrA, sDataA, sQA, encQA, decDataA;
  logic       sWrenA, decWrenA, busyA, doneA, validA;
  logic [3:0] encAddrA, decAddrA;
  logic [7:0] sAddrB, sDataB, sQB, encQB, decDataB;
  logic       sWrenB, decWrenB, busyB, doneB, validB;
  logic [4:0] encAddrB, decAddrB;

  logic [7:0] sMemA [256];
  logic [7:0] encRomA [16];
  logic [7:0] decRamA [16];
  logic [7:0] sRegA;
  logic [3:0] encRegA;
  logic [7:0] sMemB [256];
  logic [7:0] encRomB [32];
  logic [7:0] decRamB [32];
  logic [7:0] sRegB;
  logic [4:0] encRegB;

  int assertCount = 0;
  int failCount = 0;
  int mS [256];
  int mKs [32];
  int expSB [256];
  logic [7:0] expQA [$];
  logic [7:0] expQB [$];
  int idxA, idxB, expNA, expNB, cycA, cycB;
  bit expValidA, expValidB;
  logic [7:0] ptText [9];
  logic [7:0] atkText [32];

  always #10 clk = ~clk;

  rc4_decrypt_core #(.KEY_LENGTH(3), .MSG_LENGTH(9), .CHECK_ASCII(1'b0)) dutA (
    .CLOCK_50(clk), .reset(reset), .start(startA), .secret_key(keyA),
    .s_address(sAddrA), .s_data(sDataA), .s_wren(sWrenA), .s_q(sQA),
    .enc_address(encAddrA), .enc_q(encQA),
    .dec_address(decAddrA), .dec_data(decDataA), .dec_wren(decWrenA),
    .busy(busyA), .done(doneA), .key_valid(validA));

  rc4_decrypt_core #(.KEY_LENGTH(3), .MSG_LENGTH(32), .CHECK_ASCII(1'b1)) dutB (
    .CLOCK_50(clk), .reset(reset), .start(startB), .secret_key(keyB),
    .s_address(sAddrB), .s_data(sDataB), .s_wren(sWrenB), .s_q(sQB),
    .enc_address(encAddrB), .enc_q(encQB),
    .dec_address(decAddrB), .dec_data(decDataB), .dec_wren(decWrenB),
    .busy(busyB), .done(doneB), .key_valid(validB));

  // Registered-address memories with combinational read data
  always @(posedge clk) begin
    sRegA <= sAddrA;
    encRegA <= encAddrA;
    if (sWrenA) sMemA[sAddrA] <= sDataA;
    if (decWrenA) decRamA[decAddrA] <= decDataA;
    sRegB <= sAddrB;
    encRegB <= encAddrB;
    if (sWrenB) sMemB[sAddrB] <= sDataB;
    if (decWrenB) decRamB[decAddrB] <= decDataB;
  end

  assign sQA = sMemA[sRegA];
  assign encQA = encRomA[encRegA];
  assign sQB = sMemB[sRegB];
  assign encQB = encRomB[encRegB];

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Software RC4: full key schedule, then n keystream bytes into mKs, state in mS
  task automatic runModel(input logic [23:0] key, input int n);
    int i, j, t;
    for (int x = 0; x < 256; x++) mS[x] = x;
    j = 0;
    for (i = 0; i < 256; i++) begin
      j = (j + mS[i] + int'(key[8*(2-(i%3)) +: 8])) & 255;
      t = mS[i]; mS[i] = mS[j]; mS[j] = t;
    end
    i = 0; j = 0;
    for (int k = 0; k < n; k++) begin
      i = (i + 1) & 255;
      j = (j + mS[i]) & 255;
      t = mS[i]; mS[i] = mS[j]; mS[j] = t;
      mKs[k] = mS[(mS[i] + mS[j]) & 255];
    end
  endtask

  task automatic prepareA(input logic [23:0] key);
    runModel(key, 9);
    expQA.delete();
    idxA = 0;
    for (int k = 0; k < 9; k++) expQA.push_back(8'(mKs[k]) ^ encRomA[k]);
    expNA = 9;
    expValidA = 1'b1;
  endtask

  task automatic prepareB(input logic [23:0] key);
    logic [7:0] p;
    int n;
    runModel(key, 32);
    expQB.delete();
    idxB = 0;
    n = 32;
    expValidB = 1'b1;
    for (int k = 0; k < 32; k++) begin
      p = 8'(mKs[k]) ^ encRomB[k];
      expQB.push_back(p);
      if (!(((p >= 8'h61) && (p <= 8'h7A)) || (p == 8'h20))) begin
        n = k + 1;
        expValidB = 1'b0;
        break;
      end
    end
    expNB = n;
    runModel(key, n);
    for (int x = 0; x < 256; x++) expSB[x] = mS[x];
  endtask

  // Per-cycle scoreboard of decrypted-RAM writes and busy-cycle counting
  task automatic compareCycle();
    if (decWrenA) begin
      if (expQA.size() == 0) checkOutput("decA unexpected write", 1, 0);
      else begin
        checkOutput("decA addr", int'(decAddrA), idxA);
        checkOutput("decA data", int'(decDataA), int'(expQA.pop_front()));
        idxA++;
      end
    end
    if (decWrenB) begin
      if (expQB.size() == 0) checkOutput("decB unexpected write", 1, 0);
      else begin
        checkOutput("decB addr", int'(decAddrB), idxB);
        checkOutput("decB data", int'(decDataB), int'(expQB.pop_front()));
        idxB++;
      end
    end
    if (busyA) cycA++;
    if (busyB) cycB++;
  endtask

  task automatic tick();
    @(negedge clk);
    compareCycle();
  endtask

  task automatic applyStimulus(input bit forB, input logic [23:0] key);
    if (forB) begin keyB = key; startB = 1'b1; cycB = 0; end
    else begin keyA = key; startA = 1'b1; cycA = 0; end
    tick();
    startA = 1'b0;
    startB = 1'b0;
  endtask

  task automatic waitDoneA();
    int c = 0;
    while (!doneA && c < 5000) begin tick(); c++; end
    checkOutput("A done within budget", int'(doneA), 1);
    checkOutput("A key_valid", int'(validA), int'(expValidA));
    checkOutput("A byte count", idxA, expNA);
    checkOutput("A cycles", cycA, 256 + 256*6 + expNA*8);
  endtask

  task automatic waitDoneB();
    int c = 0;
    while (!doneB && c < 5000) begin tick(); c++; end
    checkOutput("B done within budget", int'(doneB), 1);
    checkOutput("B key_valid", int'(validB), int'(expValidB));
    checkOutput("B byte count", idxB, expNB);
    checkOutput("B cycles", cycB, 256 + 256*6 + expNB*8);
  endtask

  task automatic checkAtkResult();
    for (int k = 0; k < 32; k++) checkOutput("B attack text", int'(decRamB[k]), int'(atkText[k]));
    for (int x = 0; x < 256; x++) checkOutput("B S state", int'(sMemB[x]), expSB[x]);
  endtask

  initial begin
    string s;
    logic [7:0] romPt [9];
    romPt = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    ptText = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    s = "attack at dawn";
    for (int k = 0; k < 32; k++) atkText[k] = (k < s.len()) ? s[k] : 8'h20;
    for (int k = 0; k < 16; k++) encRomA[k] = (k < 9) ? romPt[k] : 8'h00;
    for (int k = 0; k < 32; k++) encRomB[k] = (k < 9) ? romPt[k] : 8'h00;
    idxA = 0; idxB = 0; cycA = 0; cycB = 0;

    repeat (3) tick();
    reset = 1'b0;
    tick();
    $display("[TB] reset state");
    checkOutput("reset busyB", int'(busyB), 0);
    checkOutput("reset doneB", int'(doneB), 0);
    checkOutput("reset validB", int'(validB), 0);
    checkOutput("reset s_wrenB", int'(sWrenB), 0);
    checkOutput("reset dec_wrenA", int'(decWrenA), 0);

    $display("[TB] INIT sweep, key 000249");
    prepareB(24'h000249);
    applyStimulus(1'b1, 24'h000249);
    for (int c = 0; c < 256; c++) begin
      checkOutput("init s_wren", int'(sWrenB), 1);
      checkOutput("init s_address", int'(sAddrB), c);
      checkOutput("init s_data", int'(sDataB), c);
      checkOutput("init busy", int'(busyB), 1);
      checkOutput("init dec_wren", int'(decWrenB), 0);
      tick();
    end
    waitDoneB();

    $display("[TB] full decrypt of Plaintext, start pulse during PRGA");
    prepareA(24'h4B6579);
    checkOutput("model ks0", mKs[0], 'hEB);
    checkOutput("model ks1", mKs[1], 'h9F);
    checkOutput("model ks8", mKs[8], 'hA7);
    applyStimulus(1'b0, 24'h4B6579);
    repeat (256 + 256*6 + 20) tick();
    keyA = 24'h123456;
    startA = 1'b1;
    tick();
    startA = 1'b0;
    checkOutput("A busy after ignored start", int'(busyA), 1);
    waitDoneA();
    for (int k = 0; k < 9; k++) checkOutput("A plaintext", int'(decRamA[k]), int'(ptText[k]));

    $display("[TB] restart from DONE");
    checkOutput("A done before restart", int'(doneA), 1);
    prepareA(24'h4B6579);
    applyStimulus(1'b0, 24'h4B6579);
    checkOutput("A done falls after start", int'(doneA), 0);
    checkOutput("A busy after restart", int'(busyA), 1);
    waitDoneA();
    for (int k = 0; k < 9; k++) checkOutput("A plaintext rerun", int'(decRamA[k]), int'(ptText[k]));

    $display("[TB] ASCII abort on Plaintext vector");
    prepareB(24'h4B6579);
    applyStimulus(1'b1, 24'h4B6579);
    waitDoneB();
    checkOutput("B abort writes", idxB, 1);
    checkOutput("B abort key_valid", int'(validB), 0);
    checkOutput("B abort byte", int'(decRamB[0]), 'h50);

    $display("[TB] attack at dawn");
    runModel(24'h4B6579, 32);
    for (int k = 0; k < 32; k++) encRomB[k] = 8'(mKs[k]) ^ atkText[k];
    prepareB(24'h4B6579);
    applyStimulus(1'b1, 24'h4B6579);
    waitDoneB();
    checkOutput("B atk key_valid", int'(validB), 1);
    checkAtkResult();

    $display("[TB] reset mid-KSA then rerun");
    prepareB(24'h4B6579);
    applyStimulus(1'b1, 24'h4B6579);
    repeat (256 + 600) tick();
    checkOutput("B at KSA i=100", int'(sAddrB), 100);
    reset = 1'b1;
    tick();
    checkOutput("rst s_address", int'(sAddrB), 0);
    checkOutput("rst s_data", int'(sDataB), 0);
    checkOutput("rst s_wren", int'(sWrenB), 0);
    checkOutput("rst enc_address", int'(encAddrB), 0);
    checkOutput("rst dec_address", int'(decAddrB), 0);
    checkOutput("rst dec_data", int'(decDataB), 0);
    checkOutput("rst dec_wren", int'(decWrenB), 0);
    checkOutput("rst busy", int'(busyB), 0);
    checkOutput("rst done", int'(doneB), 0);
    checkOutput("rst key_valid", int'(validB), 0);
    reset = 1'b0;
    tick();
    checkOutput("idle after reset", int'(busyB | doneB), 0);
    prepareB(24'h4B6579);
    applyStimulus(1'b1, 24'h4B6579);
    waitDoneB();
    checkOutput("B rerun key_valid", int'(validB), 1);
    checkAtkResult();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/rc4_decrypt_core.md
Name: rc4_decrypt_core

Overview:
Self-contained RC4 engine. It runs three phases in order:
- S-box init (s[i]=i).
- Key-scheduling shuffle with a parametrised key length.
- PRGA keystream generation, XORed with an encrypted-message ROM, writing plaintext to a decrypted-message RAM.

An optional ASCII check aborts early on a non-printable plaintext byte, so a key-search controller can instance several cores side by side, one key candidate each. The S RAM, encrypted ROM and decrypted RAM are external single-port memories.

Parameters:
KEY_LENGTH, 3, secret key length in bytes (1..32).
MSG_LENGTH, 32, message length in bytes (2..256).
CHECK_ASCII, 1, 1: abort when a plaintext byte is not 8'h61..8'h7A ('a'..'z') or 8'h20; 0: decrypt all bytes.
AW, $clog2(MSG_LENGTH), message address width.

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  begin run; sampled only in IDLE/DONE
secret_key  in  8*KEY_LENGTH  key; byte k = secret_key[8*(KEY_LENGTH-1-k) +: 8] (MSB byte first); latched on accepted start
s_address  out  8  S RAM address
s_data  out  8  S RAM write data
s_wren  out  1  S RAM write enable
s_q  in  8  S RAM read data
enc_address  out  AW  encrypted ROM address
enc_q  in  8  encrypted ROM data
dec_address  out  AW  decrypted RAM address
dec_data  out  8  decrypted byte
dec_wren  out  1  decrypted RAM write enable
busy  out  1  high from accepted start until DONE
done  out  1  high in DONE
key_valid  out  1  valid in DONE: 1 = all MSG_LENGTH bytes passed (always 1 if CHECK_ASCII=0)

Behaviour:
- Reset (any state, any cycle): go to IDLE; i, j, k = 0; all outputs 0. The next start fully re-runs INIT. No partial S state is reused.
- Memory timing: all RAM/ROM reads have registered address and unregistered q. Data for an address driven in cycle n is sampled at the end of cycle n+1 (one wait cycle per read). Writes complete in the cycle s_wren/dec_wren is high.
- Strobes: s_wren and dec_wren are single-cycle. s_address and s_data are stable in every cycle s_wren is high.
- IDLE: on start, latch secret_key, set busy=1, i=0, go to INIT. With start=0, remain in IDLE.
- INIT: one write per cycle, s_address=i, s_data=i, s_wren=1. Exactly 256 cycles. After i=255, set i=0 and j=0, go to KSA.
- KSA, per i:
  - Read s[i].
  - j = j + s[i] + key[i mod KEY_LENGTH], all mod 256.
  - Read s[j].
  - Write s[i]=old s[j], then s[j]=old s[i].
  - i mod KEY_LENGTH comes from a wrapping counter, not a divider.
  - i==j is legal; both writes store the same value.
  - After i=255, set i=0, j=0, k=0, go to PRGA.
- PRGA, per k:
  - i=i+1.
  - Read s[i]; j=j+s[i].
  - Read s[j].
  - Swap as in KSA.
  - Read s[(s[i]+s[j]) mod 256] as f, using the pre-swap values (s_i_old+s_j_old, which equal the post-swap s[j]+s[i]).
  - enc_address=k is read in parallel with any S read.
  - Write dec_address=k, dec_data=f^enc_q, dec_wren=1.
  - Check: if CHECK_ASCII and the byte fails, go to DONE with key_valid=0. The failing byte is still written.
  - Otherwise, if k=MSG_LENGTH-1, go to DONE with key_valid=1; else k=k+1.
- All index arithmetic is 8-bit modulo 256. k wraps never occur (k terminates at MSG_LENGTH-1).
- DONE: busy=0, done=1, key_valid held. A start here restarts from INIT (done drops the cycle after start is accepted). Without start, remain in DONE.
- start while busy: ignored; secret_key changes while busy are ignored.
- Each KSA iteration and each PRGA byte takes a fixed cycle count, constant per implementation. Total cycles must equal 256 + 256*T_ksa + n*T_prga, with n = number of bytes processed. Document T_ksa and T_prga in the implementation header; the bench checks determinism.

Test Plan:
- Reset, then start with key=24'h000249: first 256 S writes are address=data=0..255 on consecutive cycles; busy=1 throughout; no dec_wren during INIT.
- CHECK_ASCII=0, KEY_LENGTH=3, key="Key" (24'h4B6579), MSG_LENGTH=9, ROM=BB F3 16 E8 D9 40 AF 0A D3 -> decrypted RAM = "Plaintext" (50 6C 61 69 6E 74 65 78 74), done=1, key_valid=1.
- CHECK_ASCII=1, same vector -> byte 0 = 8'h50 fails: exactly one dec_wren pulse (address 0, data 8'h50), done=1, key_valid=0.
- CHECK_ASCII=1, ROM = "Key"-keystream XOR "attack at dawn" padded with spaces to 32 -> 32 dec_wren pulses, key_valid=1; S RAM model equals software RC4 state.
- Reset asserted mid-KSA (i=100) -> next cycle all outputs 0, state IDLE; new start reproduces the previous scenario's result exactly.
- start pulsed during PRGA with a different key -> ignored; output bytes unchanged; a start in DONE re-runs and done falls one cycle later.
